key_entry_ctrl: RTL and testbench

KEY_ENTRY_CTRL -- requirements
Module: key_entry_ctrl

---
 rtl/key_entry_ctrl_if.sv | 22 ++
 rtl/key_entry_ctrl.sv | 175 +++++++++++++++++
 tb/tb_key_entry_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/key_entry_ctrl_if.sv
// Consumer-side bus of the key entry controller: the five-slot value, the
// slot being edited, and the valid/ready handshake that offers the value.
interface key_entry_ctrl_if;
  logic [19:0] data_out;
  logic [2:0]  sel;
  logic        data_valid;
  logic        data_ready;

  modport master (
    output data_out,
    output sel,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  sel,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/key_entry_ctrl.sv
// Five debounced push keys edit five 4-bit slots (inc, dec, next slot, offer,
// clear); the packed slots are offered to a consumer over a valid/ready handshake.
module key_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk_50MHz,
  input  logic             reset,
  input  logic [4:0]       key,
  output logic [4:0]       key_led,
  key_entry_ctrl_if.master bus
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    EDIT  = 1'b0,
    OFFER = 1'b1
  } state_t;

  logic [4:0]       sync1_r;
  logic [4:0]       sync2_r;
  logic [4:0]       deb_r;
  logic [CNT_W-1:0] cnt_r [5];
  logic [4:0]       accept_s;
  logic [4:0]       press_s;
  logic [4:0]       key_led_r;

  state_t           state_r;
  state_t           state_nx_s;
  logic [4:0][3:0]  slot_r;
  logic [4:0][3:0]  slot_nx_s;
  logic [2:0]       sel_r;
  logic [2:0]       sel_nx_s;
  logic             valid_r;
  logic             valid_nx_s;

  // Acceptance fires on the stable cycle that flips the debounced state; a
  // press is that flip going 1 -> 0, so it lines up with the state change.
  always_comb begin
    accept_s = 5'b00000;
    press_s  = 5'b00000;
    for (int i = 0; i < 5; i++) begin
      accept_s[i] = (sync2_r[i] != deb_r[i]) && (cnt_r[i] == CNT_MAX);
      press_s[i]  = accept_s[i] && deb_r[i];
    end
  end

  // Synchronizer, per-key stability counters and debounced key state.
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      sync1_r <= 5'b11111;
      sync2_r <= 5'b11111;
      deb_r   <= 5'b11111;
      for (int i = 0; i < 5; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      sync1_r <= key;
      sync2_r <= sync1_r;
      for (int i = 0; i < 5; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          cnt_r[i] <= {CNT_W{1'b0}};
        end else if (accept_s[i]) begin
          deb_r[i] <= sync2_r[i];
          cnt_r[i] <= {CNT_W{1'b0}};
        end else begin
          cnt_r[i] <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Pressed-key indicators.
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      key_led_r <= 5'b00000;
    end else begin
      key_led_r <= ~deb_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state_r <= EDIT;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state: clear beats everything, including a handshake in OFFER.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      EDIT: begin
        if (press_s[4]) begin
          state_nx_s = EDIT;
        end else if (press_s[3]) begin
          state_nx_s = OFFER;
        end else begin
          state_nx_s = EDIT;
        end
      end
      OFFER: begin
        if (press_s[4]) begin
          state_nx_s = EDIT;
        end else if (valid_r && bus.data_ready) begin
          state_nx_s = EDIT;
        end else begin
          state_nx_s = OFFER;
        end
      end
      default: state_nx_s = EDIT;
    endcase
  end

  // FSM outputs: next slot contents, edit index and valid flag.
  always_comb begin
    slot_nx_s  = slot_r;
    sel_nx_s   = sel_r;
    valid_nx_s = valid_r;
    if (press_s[4]) begin
      slot_nx_s  = {5{4'd0}};
      sel_nx_s   = 3'd0;
      valid_nx_s = 1'b0;
    end else begin
      case (state_r)
        EDIT: begin
          valid_nx_s = 1'b0;
          if (press_s[3]) begin
            valid_nx_s = 1'b1;
          end else if (press_s[2]) begin
            sel_nx_s = (sel_r == 3'd4) ? 3'd0 : sel_r + 3'd1;
          end else if (press_s[1]) begin
            slot_nx_s[sel_r] = slot_r[sel_r] - 4'd1;
          end else if (press_s[0]) begin
            slot_nx_s[sel_r] = slot_r[sel_r] + 4'd1;
          end else begin
            slot_nx_s = slot_r;
          end
        end
        OFFER: begin
          if (valid_r && bus.data_ready) begin
            valid_nx_s = 1'b0;
          end else begin
            valid_nx_s = 1'b1;
          end
        end
        default: begin
          valid_nx_s = 1'b0;
        end
      endcase
    end
  end

  // Slot, index and valid registers.
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      slot_r  <= {5{4'd0}};
      sel_r   <= 3'd0;
      valid_r <= 1'b0;
    end else begin
      slot_r  <= slot_nx_s;
      sel_r   <= sel_nx_s;
      valid_r <= valid_nx_s;
    end
  end

  assign bus.data_out   = slot_r;
  assign bus.sel        = sel_r;
  assign bus.data_valid = valid_r;
  assign key_led        = key_led_r;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed bench for key_entry_ctrl with a short debounce window; a small
// behavioural model feeds a scoreboard of expected bus states.
module tb_key_entry_ctrl;
  localparam int DB = 4;

  logic       clk_50MHz = 1'b0;
  logic       reset;
  logic [4:0] key;
  logic [4:0] key_led;

  key_entry_ctrl_if bus ();

  key_entry_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .key       (key),
    .key_led   (key_led),
    .bus       (bus)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  typedef struct {
    string       tag;
    logic [19:0] d;
    logic [2:0]  s;
    logic        v;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] m_slot [5];
  logic [2:0] m_sel;
  logic       m_valid;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50MHz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] model_data();
    return {m_slot[4], m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) m_slot[i] = 4'd0;
    m_sel   = 3'd0;
    m_valid = 1'b0;
  endfunction

  // Reference behaviour of one press event (valid high means the offer state).
  function automatic void model_event(input logic [4:0] m);
    if (m[4]) model_reset();
    else if (m_valid) m_valid = m_valid;
    else if (m[3]) m_valid = 1'b1;
    else if (m[2]) m_sel = (m_sel == 3'd4) ? 3'd0 : m_sel + 3'd1;
    else if (m[1]) m_slot[m_sel] = m_slot[m_sel] - 4'd1;
    else if (m[0]) m_slot[m_sel] = m_slot[m_sel] + 4'd1;
  endfunction

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag;
    e.d   = model_data();
    e.s   = m_sel;
    e.v   = m_valid;
    sb_q.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed no entry expected one entry");
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, {bus.data_out, bus.sel, bus.data_valid}, {e.d, e.s, e.v});
    end
  endtask

  // One press: the bus must hold its old value DB+1 cycles after the edge
  // and show the new value exactly DB+2 cycles after it.
  task automatic press(input logic [4:0] m, input string tag);
    key = key & ~m;
    push_exp({tag, "_pre"});
    tick(DB + 1);
    check_sb();
    model_event(m);
    push_exp(tag);
    tick(1);
    check_sb();
    tick(2);
    key = key | m;
    tick(DB + 4);
  endtask

  initial begin
    reset = 1'b1;
    key = 5'b11111;
    bus.data_ready = 1'b0;
    model_reset();
    tick(3);
    push_exp("reset_state");
    check_sb();
    chk("reset_key_led", {19'd0, key_led}, {19'd0, 5'b00000});
    reset = 1'b0;
    tick(2);

    // A 3-cycle glitch is shorter than the debounce window.
    key[0] = 1'b0;
    tick(3);
    key[0] = 1'b1;
    tick(10);
    push_exp("glitch_no_event");
    check_sb();
    chk("glitch_key_led", {19'd0, key_led}, {19'd0, 5'b00000});

    // Long press: exact latency, indicator while held, value kept on release.
    key[0] = 1'b0;
    push_exp("hold_pre");
    tick(5);
    check_sb();
    model_event(5'b00001);
    push_exp("hold_slot0_at_6");
    tick(1);
    check_sb();
    tick(1);
    chk("hold_key_led", {19'd0, key_led}, {19'd0, 5'b00001});
    tick(13);
    push_exp("hold_no_repeat");
    check_sb();
    key[0] = 1'b1;
    tick(10);
    push_exp("after_release");
    check_sb();
    chk("release_key_led", {19'd0, key_led}, {19'd0, 5'b00000});

    // Wrap-around: clear, 16 increments, then one decrement.
    press(5'b10000, "clear");
    for (int i = 0; i < 16; i++) press(5'b00001, $sformatf("inc_%0d", i));
    press(5'b00010, "dec_wrap");

    for (int i = 0; i < 5; i++) press(5'b00100, $sformatf("sel_step_%0d", i));

    // Offer with the consumer stalled; edits are ignored while offered.
    press(5'b00001, "inc_before_offer");
    press(5'b01000, "offer");
    press(5'b00001, "offer_ignore_inc_a");
    press(5'b00001, "offer_ignore_inc_b");
    tick(18);
    push_exp("offer_held_50");
    check_sb();
    bus.data_ready = 1'b1;
    m_valid = 1'b0;
    push_exp("handshake");
    tick(1);
    check_sb();
    bus.data_ready = 1'b0;
    tick(3);
    push_exp("retained_after_handshake");
    check_sb();

    // Coincident key2 + key4: clear wins, no slot advance.
    press(5'b10000, "clear2");
    for (int i = 0; i < 5; i++) press(5'b00001, $sformatf("to5_%0d", i));
    press(5'b10100, "key2_key4_same_cycle");
    press(5'b00001, "inc_then_offer");
    press(5'b01000, "offer2");
    press(5'b10000, "clear_in_offer");

    // Clear coinciding with data_ready in OFFER: the transfer is aborted.
    press(5'b00001, "inc3");
    press(5'b01000, "offer3");
    key[4] = 1'b0;
    push_exp("abort_pre");
    tick(DB + 1);
    check_sb();
    bus.data_ready = 1'b1;
    model_event(5'b10000);
    push_exp("abort_clear_wins");
    tick(1);
    check_sb();
    bus.data_ready = 1'b0;
    tick(2);
    key[4] = 1'b1;
    tick(DB + 4);

    // Build 0x12345, offer it, then reset asynchronously mid-cycle.
    for (int s = 0; s < 5; s++) begin
      for (int n = 0; n < 5 - s; n++) press(5'b00001, $sformatf("build_s%0d_%0d", s, n));
      press(5'b00100, $sformatf("build_next_%0d", s));
    end
    press(5'b01000, "offer_12345");
    chk("offer_value", {4'd0, bus.data_out}, 24'h012345);
    key[1] = 1'b0;
    tick(8);
    chk("offer_key1_led", {19'd0, key_led}, {19'd0, 5'b00010});
    push_exp("offer_key1_ignored");
    check_sb();
    #4;
    reset = 1'b1;
    #1;
    model_reset();
    push_exp("async_reset");
    check_sb();
    chk("async_reset_key_led", {19'd0, key_led}, {19'd0, 5'b00000});
    tick(3);
    reset = 1'b0;

    // Key held through reset yields exactly one event after release of reset.
    push_exp("held_through_reset_pre");
    tick(DB + 1);
    check_sb();
    model_event(5'b00010);
    push_exp("held_through_reset_event");
    tick(1);
    check_sb();
    tick(10);
    push_exp("held_no_repeat");
    check_sb();
    key[1] = 1'b1;
    tick(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
